cdic_sample_pacer: RTL and testbench

CDIC_SAMPLE_PACER -- requirements
Module: cdic_sample_pacer

---
 rtl/cdic_sample_pacer.sv | 189 ++++++++++++++++++
 tb/tb_cdic_sample_pacer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cdic_sample_pacer.sv
`default_nettype none
// ============================================================================
// Module   : cdic_sample_pacer
// Purpose  : Stereo sample FIFO that is filled by the audio decoder and drained
//            one entry per DAC sample tick. The tick rate is 37.8 kHz or
//            44.1 kHz. Playback starts only after the FIFO is half full. An
//            empty FIFO at a tick raises a sticky underrun flag and sends the
//            pacer back to priming.
// Ports    :
//    clk            - system clock, rising edge
//    reset          - synchronous active-low reset
//    sample_tick37  - 37.8 kHz one-cycle sample pulse
//    sample_tick44  - 44.1 kHz one-cycle sample pulse
//    rate44         - rate select, latched when playback is enabled
//    enable         - playback enable; deasserting it flushes the FIFO
//    in_valid/in_ready/in_left/in_right - decoder push handshake
//    out_left/out_right - current DAC sample
//    out_strobe     - one-cycle pulse when a new sample is presented
//    underrun       - sticky underrun flag
//    clear_underrun - clears the underrun flag
//    fill_level     - FIFO occupancy, 0..DEPTH
// Revision : 1.0 - initial release
// ============================================================================
module cdic_sample_pacer #(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     sample_tick37,
   input  logic                     sample_tick44,
   input  logic                     rate44,
   input  logic                     enable,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [15:0]       in_left,
   input  logic signed [15:0]       in_right,
   output logic signed [15:0]       out_left,
   output logic signed [15:0]       out_right,
   output logic                     out_strobe,
   output logic                     underrun,
   input  logic                     clear_underrun,
   output logic [$clog2(DEPTH):0]   fill_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
   localparam logic [CW-1:0] C_HALF = CW'(DEPTH / 2);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      PLAY  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [AW-1:0]        wptr_q, wptr_d;
   logic [AW-1:0]        rptr_q, rptr_d;
   logic [CW-1:0]        count_q, count_d;
   logic signed [15:0]   out_left_q, out_left_d;
   logic signed [15:0]   out_right_q, out_right_d;
   logic                 strobe_q, strobe_d;
   logic                 underrun_q, underrun_d;
   logic                 rate_q, rate_d;
   logic [31:0]          mem_q [DEPTH];

   logic                 w_full;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_tick;
   logic                 w_ur_evt;

   // Ready is gated by reset so that no write can land while reset is held.
   assign w_full   = (count_q == C_FULL);
   assign in_ready = reset && enable && !w_full;
   assign w_push   = in_valid && in_ready;
   assign w_tick   = rate_q ? sample_tick44 : sample_tick37;

   always_comb begin
      state_d     = state_q;
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      count_d     = count_q;
      out_left_d  = out_left_q;
      out_right_d = out_right_q;
      strobe_d    = 1'b0;
      rate_d      = rate_q;
      w_pop       = 1'b0;
      w_ur_evt    = 1'b0;
      underrun_d  = clear_underrun ? 1'b0 : underrun_q;

      if (!enable) begin
         // Flush: discard contents and silence the DAC; underrun is kept.
         state_d     = IDLE;
         wptr_d      = '0;
         rptr_d      = '0;
         count_d     = '0;
         out_left_d  = '0;
         out_right_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d     = PRIME;
               rate_d      = rate44;
               out_left_d  = '0;
               out_right_d = '0;
            end
            PRIME: begin
               // Ticks are ignored here, including on the cycle that enters PLAY.
               if (count_q >= C_HALF) begin
                  state_d = PLAY;
               end
            end
            PLAY: begin
               if (w_tick) begin
                  if (count_q != '0) begin
                     w_pop = 1'b1;
                  end else begin
                     w_ur_evt    = 1'b1;
                     state_d     = PRIME;
                     out_left_d  = '0;
                     out_right_d = '0;
                  end
               end
            end
            default: state_d = IDLE;
         endcase

         if (w_push) begin
            wptr_d = wptr_q + 1'b1;
         end
         if (w_pop) begin
            rptr_d      = rptr_q + 1'b1;
            out_left_d  = mem_q[rptr_q][31:16];
            out_right_d = mem_q[rptr_q][15:0];
            strobe_d    = 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end

      // A new underrun takes priority over a simultaneous clear.
      if (w_ur_evt) begin
         underrun_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         out_left_q  <= '0;
         out_right_q <= '0;
         strobe_q    <= 1'b0;
         underrun_q  <= 1'b0;
         rate_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         out_left_q  <= out_left_d;
         out_right_q <= out_right_d;
         strobe_q    <= strobe_d;
         underrun_q  <= underrun_d;
         rate_q      <= rate_d;
      end
   end

   // Storage needs no reset: occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (w_push) begin
         mem_q[wptr_q] <= {in_left, in_right};
      end
   end

   assign out_left   = out_left_q;
   assign out_right  = out_right_q;
   assign out_strobe = strobe_q;
   assign underrun   = underrun_q;
   assign fill_level = count_q;

endmodule
`default_nettype wire

// File: tb/tb_cdic_sample_pacer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdic_sample_pacer
// Purpose  : Directed self-checking bench for cdic_sample_pacer (DEPTH=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdic_sample_pacer;

   logic               clk = 1'b0;
   logic               reset;
   logic               sample_tick37;
   logic               sample_tick44;
   logic               rate44;
   logic               enable;
   logic               in_valid;
   logic               in_ready;
   logic signed [15:0] in_left;
   logic signed [15:0] in_right;
   logic signed [15:0] out_left;
   logic signed [15:0] out_right;
   logic               out_strobe;
   logic               underrun;
   logic               clear_underrun;
   logic [4:0]         fill_level;

   int tests  = 0;
   int failed = 0;

   cdic_sample_pacer #(.DEPTH(16)) dut (
      .clk            (clk),
      .reset          (reset),
      .sample_tick37  (sample_tick37),
      .sample_tick44  (sample_tick44),
      .rate44         (rate44),
      .enable         (enable),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_left        (in_left),
      .in_right       (in_right),
      .out_left       (out_left),
      .out_right      (out_right),
      .out_strobe     (out_strobe),
      .underrun       (underrun),
      .clear_underrun (clear_underrun),
      .fill_level     (fill_level)
   );

   always #5 clk = ~clk;

   // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] l, input logic [15:0] r);
      in_left  = l;
      in_right = r;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic tick44();
      sample_tick44 = 1'b1;
      step();
      sample_tick44 = 1'b0;
   endtask

   task automatic tick37();
      sample_tick37 = 1'b1;
      step();
      sample_tick37 = 1'b0;
   endtask

   task automatic flush();
      enable = 1'b0; in_valid = 1'b0;
      sample_tick37 = 1'b0; sample_tick44 = 1'b0;
      clear_underrun = 1'b1;
      step();
      clear_underrun = 1'b0;
      step();
   endtask

   // Enable playback, fill to the priming threshold, then enter PLAY.
   task automatic start_play(input logic r, input logic [15:0] base);
      rate44 = r; enable = 1'b1;
      step();
      for (int i = 0; i < 8; i++) push(16'(base + i), 16'(base + 16'h0100 + i));
      step();
   endtask

   task automatic test_reset();
      reset = 1'b0; enable = 1'b1; rate44 = 1'b0;
      in_valid = 1'b0; sample_tick37 = 1'b0; sample_tick44 = 1'b0;
      clear_underrun = 1'b0; in_left = '0; in_right = '0;
      step(); step();
      tests++; if (in_ready !== 1'b0) begin failed++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
      tests++; if (fill_level !== 5'd0) begin failed++; $display("FAIL reset_fill got %0d want 0", fill_level); end
      tests++; if ({out_left, out_right, out_strobe, underrun} !== 34'd0)
         begin failed++; $display("FAIL reset_outputs got %h %h %b %b want 0", out_left, out_right, out_strobe, underrun); end
      reset = 1'b1; enable = 1'b0;
      step();
   endtask

   task automatic test_prime_play();
      start_play(1'b1, 16'h1000);
      tests++; if (fill_level !== 5'd8) begin failed++; $display("FAIL pp_fill got %0d want 8", fill_level); end
      tick37();
      tests++; if (out_strobe !== 1'b0 || fill_level !== 5'd8)
         begin failed++; $display("FAIL pp_tick37_ignored strobe %b fill %0d want 0 8", out_strobe, fill_level); end
      tick44();
      tests++; if (out_strobe !== 1'b1 || out_left !== 16'sh1000 || out_right !== 16'sh1100)
         begin failed++; $display("FAIL pp_first_pop got %b %h %h want 1 1000 1100", out_strobe, out_left, out_right); end
      tests++; if (fill_level !== 5'd7) begin failed++; $display("FAIL pp_fill_after got %0d want 7", fill_level); end
      step();
      tests++; if (out_strobe !== 1'b0 || out_left !== 16'sh1000)
         begin failed++; $display("FAIL pp_hold got %b %h want 0 1000", out_strobe, out_left); end
   endtask

   // Fill completely, refuse the 17th push, drain in order, then underrun.
   task automatic test_full_and_underrun();
      logic [15:0] e;
      flush();
      rate44 = 1'b1; enable = 1'b1;
      step();
      for (int i = 0; i < 16; i++) push(16'(16'h3000 + i), 16'(16'h3100 + i));
      tests++; if (in_ready !== 1'b0 || fill_level !== 5'd16)
         begin failed++; $display("FAIL full_state ready %b fill %0d want 0 16", in_ready, fill_level); end
      push(16'hDEAD, 16'hBEEF);
      tests++; if (fill_level !== 5'd16) begin failed++; $display("FAIL full_no_accept got %0d want 16", fill_level); end
      for (int i = 0; i < 16; i++) begin
         tick44();
         e = 16'(16'h3000 + i);
         tests++; if (out_strobe !== 1'b1 || out_left !== e)
            begin failed++; $display("FAIL drain_order[%0d] got %b %h want 1 %h", i, out_strobe, out_left, e); end
      end
      tests++; if (fill_level !== 5'd0) begin failed++; $display("FAIL drain_empty got %0d want 0", fill_level); end
      tick44();
      tests++; if (underrun !== 1'b1 || out_strobe !== 1'b0 || out_left !== 16'sd0 || out_right !== 16'sd0)
         begin failed++; $display("FAIL underrun_set got %b %b %h %h want 1 0 0 0", underrun, out_strobe, out_left, out_right); end
      // Back in PRIME a pushed entry must not be popped by a tick.
      push(16'h3A00, 16'h3B00);
      tick44();
      tests++; if (out_strobe !== 1'b0 || fill_level !== 5'd1)
         begin failed++; $display("FAIL underrun_prime strobe %b fill %0d want 0 1", out_strobe, fill_level); end
      clear_underrun = 1'b1;
      step();
      clear_underrun = 1'b0;
      tests++; if (underrun !== 1'b0) begin failed++; $display("FAIL underrun_clear got %b want 0", underrun); end
   endtask

   task automatic test_simultaneous();
      logic [15:0] exp_q [$];
      flush();
      start_play(1'b1, 16'h4000);
      for (int i = 0; i < 3; i++) tick44();
      tests++; if (fill_level !== 5'd5) begin failed++; $display("FAIL sim_pre_fill got %0d want 5", fill_level); end
      in_left = 16'h4100; in_right = 16'h4200; in_valid = 1'b1; sample_tick44 = 1'b1;
      step();
      in_valid = 1'b0; sample_tick44 = 1'b0;
      tests++; if (fill_level !== 5'd5 || out_left !== 16'sh4003)
         begin failed++; $display("FAIL sim_same_cycle fill %0d out %h want 5 4003", fill_level, out_left); end
      exp_q = '{16'h4004, 16'h4005, 16'h4006, 16'h4007, 16'h4100};
      for (int i = 0; i < 5; i++) begin
         tick44();
         tests++; if (out_left !== exp_q[i])
            begin failed++; $display("FAIL sim_order[%0d] got %h want %h", i, out_left, exp_q[i]); end
      end
   endtask

   task automatic test_rate_latch();
      flush();
      start_play(1'b0, 16'h5000);
      rate44 = 1'b1;
      tick44();
      tests++; if (out_strobe !== 1'b0 || fill_level !== 5'd8)
         begin failed++; $display("FAIL rate_ignore44 strobe %b fill %0d want 0 8", out_strobe, fill_level); end
      tick37();
      tests++; if (out_strobe !== 1'b1 || out_left !== 16'sh5000)
         begin failed++; $display("FAIL rate_pop37 got %b %h want 1 5000", out_strobe, out_left); end
      flush();
      start_play(1'b1, 16'h6000);
      tick37();
      tests++; if (out_strobe !== 1'b0) begin failed++; $display("FAIL rate_relatch37 got %b want 0", out_strobe); end
      tick44();
      tests++; if (out_strobe !== 1'b1 || out_left !== 16'sh6000)
         begin failed++; $display("FAIL rate_relatch44 got %b %h want 1 6000", out_strobe, out_left); end
   endtask

   task automatic test_flush();
      flush();
      start_play(1'b1, 16'h7000);
      tick44();
      tests++; if (fill_level !== 5'd7 || out_left !== 16'sh7000)
         begin failed++; $display("FAIL flush_pre fill %0d out %h want 7 7000", fill_level, out_left); end
      enable = 1'b0;
      step();
      tests++; if (fill_level !== 5'd0 || out_left !== 16'sd0 || out_right !== 16'sd0 || out_strobe !== 1'b0)
         begin failed++; $display("FAIL flush_post fill %0d out %h %h strobe %b want 0 0 0 0", fill_level, out_left, out_right, out_strobe); end
   endtask

   task automatic test_reset_mid_play();
      flush();
      start_play(1'b1, 16'h7100);
      tick44();
      reset = 1'b0;
      step();
      tests++; if (fill_level !== 5'd0 || {out_left, out_right, out_strobe, underrun} !== 34'd0 || in_ready !== 1'b0)
         begin failed++; $display("FAIL rst_mid fill %0d out %h %h %b %b ready %b want all 0", fill_level, out_left, out_right, out_strobe, underrun, in_ready); end
      reset = 1'b1; enable = 1'b0;
      step();
      start_play(1'b1, 16'h7200);
      tick44();
      tests++; if (out_strobe !== 1'b1 || out_left !== 16'sh7200)
         begin failed++; $display("FAIL rst_resume got %b %h want 1 7200", out_strobe, out_left); end
   endtask

   initial begin
      test_reset();
      test_prime_play();
      test_full_and_underrun();
      test_simultaneous();
      test_rate_latch();
      test_flush();
      test_reset_mid_play();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
`default_nettype wire
